// File: rtl/bsg_fifo_narrow_pkg.sv
// Shared definitions for the narrowing FIFO: slice emission order and
// the width of the per-word slice-count field.
package bsg_fifo_narrow_pkg;

    typedef enum logic {
        e_msb_first = 1'b0,
        e_lsb_first = 1'b1
    } slice_order_e;

    // A ratio of 1 would need a zero-width length field; keep it at least 1 bit.
    function automatic int lg_ratio_f(input int ratio);
        return ($clog2(ratio) > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/bsg_channel_narrow_gen.sv
// Walks the slices of the head word: slice counter, slice mux, and the
// last-slice / dequeue decision.
module bsg_channel_narrow_gen
    import bsg_fifo_narrow_pkg::*;
#(
    parameter int width_in_p   = 32,
    parameter int ratio_p      = 2,
    parameter int lsb_to_msb_p = 1,
    localparam int width_out_p = width_in_p / ratio_p,
    localparam int lg_ratio    = lg_ratio_f(ratio_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [width_in_p-1:0]  data_i,
    input  logic [lg_ratio-1:0]    len_i,
    input  logic                   yumi_i,
    output logic                   v_o,
    output logic [width_out_p-1:0] data_o,
    output logic                   last_o,
    output logic                   deq_o
);

    localparam slice_order_e order_lp = (lsb_to_msb_p != 0) ? e_lsb_first : e_msb_first;
    localparam logic [lg_ratio-1:0] max_idx_lp = lg_ratio'(ratio_p - 1);

    logic [lg_ratio-1:0] cnt_r;
    logic [lg_ratio-1:0] idx;

    assign idx    = (order_lp == e_lsb_first) ? cnt_r : (max_idx_lp - cnt_r);
    assign v_o    = v_i;
    assign data_o = data_i[idx*width_out_p +: width_out_p];
    assign last_o = v_i & (cnt_r == len_i);
    assign deq_o  = yumi_i & last_o;

    // yumi without a valid head is ignored, so the count only moves when v_i is set.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else if (yumi_i && v_i) begin
            if (last_o) cnt_r <= '0;
            else        cnt_r <= cnt_r + lg_ratio'(1);
        end
    end

endmodule

// File: rtl/bsg_fifo_1r1w_narrowed_gen.sv
// Word-wide FIFO whose head word is emitted as a sequence of narrower
// slices, only as many slices as the word's length field says are valid.
module bsg_fifo_1r1w_narrowed_gen
    import bsg_fifo_narrow_pkg::*;
#(
    parameter int width_in_p   = 32,
    parameter int ratio_p      = 2,
    parameter int els_p        = 64,
    parameter int lsb_to_msb_p = 1,
    localparam int width_out_p = width_in_p / ratio_p,
    localparam int lg_ratio    = lg_ratio_f(ratio_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [width_in_p-1:0]  data_i,
    input  logic [lg_ratio-1:0]    len_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [width_out_p-1:0] data_o,
    output logic                   last_o,
    input  logic                   yumi_i
);

    localparam int lg_els  = $clog2(els_p);
    localparam int entry_w = width_in_p + lg_ratio;
    localparam logic [lg_els:0] full_count_lp = (lg_els + 1)'(els_p);

    logic [entry_w-1:0]  mem [els_p];
    logic [lg_els-1:0]   wptr_r, rptr_r;
    logic [lg_els:0]     count_r, count_next;
    logic                ready_r;
    logic                enq, deq, head_v;
    logic [entry_w-1:0]  head;

    assign enq     = v_i & ready_r;
    assign head_v  = (count_r != '0);
    assign head    = mem[rptr_r];
    assign ready_o = ready_r;

    always_comb begin
        count_next = count_r;
        case ({enq, deq})
            2'b10:   count_next = count_r + (lg_els + 1)'(1);
            2'b01:   count_next = count_r - (lg_els + 1)'(1);
            default: count_next = count_r;
        endcase
    end

    // Storage is deliberately not reset; only pointers and occupancy are.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_r] <= {data_i, len_i};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            ready_r <= 1'b0;
        end else begin
            if (enq) wptr_r <= wptr_r + lg_els'(1);
            if (deq) rptr_r <= rptr_r + lg_els'(1);
            count_r <= count_next;
            ready_r <= (count_next != full_count_lp);
        end
    end

    bsg_channel_narrow_gen #(
        .width_in_p   (width_in_p),
        .ratio_p      (ratio_p),
        .lsb_to_msb_p (lsb_to_msb_p)
    ) u_channel (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (head_v),
        .data_i    (head[entry_w-1 -: width_in_p]),
        .len_i     (head[lg_ratio-1:0]),
        .yumi_i    (yumi_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .last_o    (last_o),
        .deq_o     (deq)
    );

endmodule

// File: tb/tb_bsg_fifo_1r1w_narrowed_gen.sv
// Directed bench for the narrowing FIFO: two instances (LSB-first and
// MSB-first), 32-bit words split into four byte slices, depth four.
module tb_bsg_fifo_1r1w_narrowed_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_i;
    logic [1:0]  len_i;
    logic        v0, v1, yumi0, yumi1;
    logic        ready0, ready1, vo0, vo1, last0, last1;
    logic [7:0]  dout0, dout1;

    int checks   = 0;
    int failures = 0;

    bsg_fifo_1r1w_narrowed_gen #(
        .width_in_p(32), .ratio_p(4), .els_p(4), .lsb_to_msb_p(1)
    ) u_dut_lsb (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i), .len_i(len_i),
        .v_i(v0), .ready_o(ready0), .v_o(vo0), .data_o(dout0),
        .last_o(last0), .yumi_i(yumi0)
    );

    bsg_fifo_1r1w_narrowed_gen #(
        .width_in_p(32), .ratio_p(4), .els_p(4), .lsb_to_msb_p(0)
    ) u_dut_msb (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i), .len_i(len_i),
        .v_i(v1), .ready_o(ready1), .v_o(vo1), .data_o(dout1),
        .last_o(last1), .yumi_i(yumi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Single-word enqueue into the LSB-first instance; returns on the next negedge.
    task automatic enq0(input logic [31:0] d, input logic [1:0] l);
        @(negedge clk);
        data_i = d; len_i = l; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
    endtask

    // Check the current slice of the LSB-first instance, then consume it.
    task automatic take0(input string tag, input logic [7:0] exp_d, input logic exp_last);
        chk({tag, "_v"}, 32'(vo0), 32'd1);
        chk({tag, "_data"}, 32'(dout0), 32'(exp_d));
        chk({tag, "_last"}, 32'(last0), 32'(exp_last));
        yumi0 = 1'b1;
        @(negedge clk);
        yumi0 = 1'b0;
    endtask

    logic [7:0] exp_lsb [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] exp_msb [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};

    initial begin
        rst_n = 1'b0; data_i = '0; len_i = '0;
        v0 = 1'b0; v1 = 1'b0; yumi0 = 1'b0; yumi1 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_v",     32'(vo0),    32'd0);
        chk("rst_last",  32'(last0),  32'd0);
        chk("rst_ready", 32'(ready0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready0), 32'd1);
        chk("post_rst_v",     32'(vo0),    32'd0);

        // Full-length word, both slice orders, yumi every cycle
        @(negedge clk);
        data_i = 32'hDDCCBBAA; len_i = 2'd3; v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lsb_data%0d", i), 32'(dout0), 32'(exp_lsb[i]));
            chk($sformatf("lsb_last%0d", i), 32'(last0), 32'(i == 3));
            chk($sformatf("msb_data%0d", i), 32'(dout1), 32'(exp_msb[i]));
            chk($sformatf("msb_last%0d", i), 32'(last1), 32'(i == 3));
            yumi0 = 1'b1; yumi1 = 1'b1;
            @(negedge clk);
        end
        yumi0 = 1'b0; yumi1 = 1'b0;
        chk("lsb_empty", 32'(vo0), 32'd0);
        chk("msb_empty", 32'(vo1), 32'd0);

        // Short words: unused slices never appear
        enq0(32'h11223344, 2'd1);
        enq0(32'h55667788, 2'd0);
        take0("short_a0", 8'h44, 1'b0);
        take0("short_a1", 8'h33, 1'b1);
        take0("short_b0", 8'h88, 1'b1);
        chk("short_empty", 32'(vo0), 32'd0);
        chk("short_last_idle", 32'(last0), 32'd0);

        // yumi while empty must not disturb the slice counter
        yumi0 = 1'b1;
        @(negedge clk);
        yumi0 = 1'b0;
        chk("illegal_yumi_v", 32'(vo0), 32'd0);

        // Fill to capacity, then wrap the pointers
        for (int i = 0; i < 4; i++) begin
            data_i = 32'h0000_00A0 + 32'(i); len_i = 2'd0; v0 = 1'b1;
            @(negedge clk);
        end
        chk("full_ready", 32'(ready0), 32'd0);
        data_i = 32'h0000_00A4;
        take0("full_w0", 8'hA0, 1'b1);
        v0 = 1'b1;
        chk("refill_ready", 32'(ready0), 32'd1);
        @(negedge clk);
        v0 = 1'b0;
        chk("refull_ready", 32'(ready0), 32'd0);
        for (int i = 1; i < 5; i++)
            take0($sformatf("wrap_w%0d", i), 8'hA0 + 8'(i), 1'b1);
        chk("wrap_empty", 32'(vo0), 32'd0);

        // Streaming one word per cycle with no bubbles
        for (int k = 0; k < 8; k++) begin
            data_i = 32'h0000_0050 + 32'(k); len_i = 2'd0; v0 = 1'b1;
            if (k > 0) begin
                chk($sformatf("stream_v%0d", k), 32'(vo0), 32'd1);
                chk($sformatf("stream_d%0d", k), 32'(dout0), 32'h50 + 32'(k - 1));
                chk($sformatf("stream_rdy%0d", k), 32'(ready0), 32'd1);
                yumi0 = 1'b1;
            end
            @(negedge clk);
        end
        v0 = 1'b0;
        chk("stream_tail", 32'(dout0), 32'h57);
        yumi0 = 1'b1;
        @(negedge clk);
        yumi0 = 1'b0;
        chk("stream_empty", 32'(vo0), 32'd0);

        // Reset in the middle of a word
        enq0(32'hDDCCBBAA, 2'd3);
        take0("mid_s0", 8'hAA, 1'b0);
        take0("mid_s1", 8'hBB, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v",     32'(vo0),    32'd0);
        chk("mid_rst_ready", 32'(ready0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_post_v",     32'(vo0),    32'd0);
        chk("mid_post_ready", 32'(ready0), 32'd1);
        enq0(32'h44332211, 2'd3);
        chk("mid_restart_data", 32'(dout0), 32'h11);
        chk("mid_restart_last", 32'(last0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
